// File: rtl/riego_pkg.sv
// Shared definitions for the irrigation supply blocks.
// State encoding and default timing constants.
package riego_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } estado_t;

  localparam int RIEGO_TICK_DIV = 25000;
  localparam int RIEGO_N_ZONAS  = 4;

endpackage

// File: rtl/arbitro_valvulas_divisor_tick.sv
// Tick prescaler: one-cycle tick every TICK_DIV clocks.
// Synchronous clear restarts the period from zero.
module divisor_tick
  import riego_pkg::*;
#(
  parameter int TICK_DIV = RIEGO_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] TERM = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == TERM);

  // prescaler: wraps to zero on terminal count or clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/arbitro_valvulas.sv
// Round-robin arbiter for the shared treated-water valve.
// One zone granted at a time, watchdog plus settling guard.
module arbitro_valvulas
  import riego_pkg::*;
#(
  parameter int N_ZONAS     = RIEGO_N_ZONAS,
  parameter int TICK_DIV    = RIEGO_TICK_DIV,
  parameter int MAX_TICKS   = 10000,
  parameter int GUARD_TICKS = 100
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_ZONAS-1:0]         req,
  input  logic [N_ZONAS-1:0]         done,
  output logic [N_ZONAS-1:0]         grant,
  output logic                       busy,
  output logic [$clog2(N_ZONAS)-1:0] zona_activa,
  output logic                       timeout_pulse
);

  localparam int ZW  = $clog2(N_ZONAS);
  localparam int TOP = (MAX_TICKS > GUARD_TICKS) ? MAX_TICKS : GUARD_TICKS;
  localparam int CW  = $clog2(TOP + 1);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] LIM_WD  = CW'(MAX_TICKS);
  localparam logic [CW-1:0] LIM_GD  = CW'(GUARD_TICKS);

  estado_t           state;
  estado_t           state_n;
  logic [N_ZONAS-1:0] grant_n;
  logic [ZW-1:0]     zona_n;
  logic [ZW-1:0]     sel;
  logic              to_n;
  logic              clr;
  logic              tick;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;

  // first requester strictly after ptr, wrapping without a modulo
  function automatic logic [ZW-1:0] rr_pick(
    input logic [N_ZONAS-1:0] r,
    input logic [ZW-1:0]      ptr
  );
    logic [ZW-1:0] res;
    logic [ZW-1:0] k;
    int            idx;
    res = ptr;
    for (int i = N_ZONAS; i >= 1; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_ZONAS) idx = idx - N_ZONAS;
      k = ZW'(idx);
      if (r[k]) res = k;
    end
    return res;
  endfunction

  divisor_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .tick (tick)
  );

  assign cnt_inc = (tick && cnt != CNT_MAX) ? cnt + CW'(1) : cnt;
  assign busy    = (state != IDLE);
  assign sel     = rr_pick(req, zona_activa);

  // next state, grant vector and timer clear
  always_comb begin
    state_n = state;
    grant_n = grant;
    zona_n  = zona_activa;
    to_n    = 1'b0;
    clr     = 1'b0;
    unique case (state)
      IDLE: begin
        clr = 1'b1;
        if (|req) begin
          state_n      = GRANT;
          zona_n       = sel;
          grant_n      = '0;
          grant_n[sel] = 1'b1;
        end
      end
      GRANT: begin
        if (done[zona_activa] || !req[zona_activa]) begin
          state_n = GUARD;
          grant_n = '0;
          clr     = 1'b1;
        end else if (cnt_inc == LIM_WD) begin
          state_n = GUARD;
          grant_n = '0;
          to_n    = 1'b1;
          clr     = 1'b1;
        end
      end
      GUARD: begin
        grant_n = '0;
        if (cnt_inc == LIM_GD) begin
          state_n = IDLE;
          clr     = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        clr     = 1'b1;
      end
    endcase
  end

  // registered state and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      zona_activa   <= ZW'(N_ZONAS - 1);
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      grant         <= grant_n;
      zona_activa   <= zona_n;
      timeout_pulse <= to_n;
    end
  end

  // saturating tick counter, shared by watchdog and guard
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_arbitro_valvulas.sv
// Scoreboard bench for arbitro_valvulas.
// Reference model predicts each grant; monitor checks it.
module tb_arbitro_valvulas;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int M  = 10;
  localparam int G  = 2;
  localparam int MD = M * D;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       busy;
  logic [1:0] zona_activa;
  logic       timeout_pulse;

  int tests;
  int fails;

  typedef struct {
    int zone;
    int gap;
  } st_t;

  typedef struct {
    int len;
    int to;
  } en_t;

  st_t q_start[$];
  en_t q_end[$];

  int m_owner;
  int m_elapsed;
  int m_guard;
  int m_last;
  int m_low;

  arbitro_valvulas #(
    .N_ZONAS    (N),
    .TICK_DIV   (D),
    .MAX_TICKS  (M),
    .GUARD_TICKS(G)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .done         (done),
    .grant        (grant),
    .busy         (busy),
    .zona_activa  (zona_activa),
    .timeout_pulse(timeout_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_owner   = -1;
    m_elapsed = 0;
    m_guard   = 0;
    m_last    = N - 1;
    m_low     = 0;
    q_start.delete();
    q_end.delete();
  endfunction

  // one clock edge of the reference: grant length in cycles,
  // guard as a plain countdown, round robin by scanning indices
  function automatic void model_edge(input logic [3:0] r, input logic [3:0] d);
    st_t s;
    en_t e;
    int  z;
    if (m_owner >= 0) begin
      if (d[m_owner] || !r[m_owner]) begin
        e.len = m_elapsed + 1;
        e.to  = 0;
        q_end.push_back(e);
        m_owner = -1;
        m_guard = G * D;
        m_low   = 0;
      end else if (m_elapsed + 1 == MD) begin
        e.len = MD;
        e.to  = 1;
        q_end.push_back(e);
        m_owner = -1;
        m_guard = G * D;
        m_low   = 0;
      end else begin
        m_elapsed++;
      end
    end else if (m_guard > 0) begin
      m_low++;
      m_guard--;
    end else begin
      m_low++;
      if (r != 4'b0) begin
        z = -1;
        for (int i = 1; i <= N; i++) begin
          if (z < 0 && r[(m_last + i) % N]) z = (m_last + i) % N;
        end
        s.zone = z;
        s.gap  = m_low;
        q_start.push_back(s);
        m_owner   = z;
        m_last    = z;
        m_elapsed = 0;
        m_low     = 0;
      end
    end
  endfunction

  task automatic step(input logic [3:0] r, input logic [3:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
  endtask

  task automatic reset_mid();
    #2;
    reset = 1'b1;
    #1;
    chk("async_grant", int'(grant), 0);
    chk("async_busy", int'(busy), 0);
    req  = 4'b0;
    done = 4'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // monitor: pops expectations when grants start and end
  initial begin : monitor
    logic [3:0] prev;
    int         len_o;
    int         low_o;
    st_t        s;
    en_t        e;
    prev  = 4'b0;
    len_o = 0;
    low_o = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev  = 4'b0;
        len_o = 0;
        low_o = 0;
      end else begin
        if (grant != 4'b0 && prev == 4'b0) begin
          if (q_start.size() == 0) begin
            chk("unexpected_grant", int'(grant), 0);
          end else begin
            s = q_start.pop_front();
            chk("grant_vec", int'(grant), 1 << s.zone);
            chk("zona_activa", int'(zona_activa), s.zone);
            chk("busy_grant", int'(busy), 1);
            chk("gap_len", low_o, s.gap);
          end
          chk("to_spurious", int'(timeout_pulse), 0);
          len_o = 1;
          low_o = 0;
        end else if (grant != 4'b0) begin
          chk("grant_stable", int'(grant), int'(prev));
          chk("to_spurious", int'(timeout_pulse), 0);
          len_o++;
        end else if (prev != 4'b0) begin
          if (q_end.size() == 0) begin
            chk("unexpected_release", len_o, -1);
          end else begin
            e = q_end.pop_front();
            chk("grant_len", len_o, e.len);
            chk("timeout_pulse", int'(timeout_pulse), e.to);
            chk("busy_guard", int'(busy), 1);
          end
          low_o = 1;
        end else begin
          chk("to_spurious", int'(timeout_pulse), 0);
          low_o++;
        end
        prev = grant;
      end
    end
  end

  initial begin : driver
    logic [3:0] r;
    logic [3:0] d;
    bit         hit;
    int         after;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    req   = 4'b0;
    done  = 4'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_to", int'(timeout_pulse), 0);
    chk("rst_zona", int'(zona_activa), N - 1);
    reset = 1'b0;

    // reset release, then zone 0 releases and zone 2 follows
    repeat (3) step(4'b0101, 4'b0);
    step(4'b0101, 4'b0001);
    repeat (12) step(4'b0101, 4'b0);

    // only zone 3 requesting: watchdog and re-grant
    repeat (110) step(4'b1000, 4'b0);

    // zone 1: done on the expiry cycle, foreign done ignored
    hit   = 1'b0;
    after = 0;
    for (int i = 0; i < 300 && after < 12; i++) begin
      d = 4'b0;
      if (m_owner == 1) begin
        if (m_elapsed == MD - 1) begin
          d   = 4'b0010;
          hit = 1'b1;
        end else if (m_elapsed % 5 == 2) begin
          d = 4'b0100;
        end
      end
      if (hit) after++;
      step(4'b0010, d);
    end
    chk("expiry_release_reached", int'(hit), 1);

    // reset in the middle of a grant
    for (int i = 0; i < 60; i++) begin
      if (m_owner >= 0 && m_elapsed == 3) break;
      step(4'b1111, 4'b0);
    end
    chk("mid_grant_reached", m_elapsed, 3);
    reset_mid();
    repeat (4) step(4'b1111, 4'b0);

    // fairness with every zone requesting
    for (int i = 0; i < 80; i++) begin
      d = 4'b0;
      if (m_owner >= 0 && m_elapsed == 2) d[m_owner] = 1'b1;
      step(4'b1111, d);
    end

    // random traffic
    r = 4'($urandom);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) r = 4'($urandom);
      d = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      step(r, d);
    end

    // drain
    repeat (15) step(4'b0, 4'b0);
    @(negedge clk);
    #1;
    chk("q_start_left", q_start.size(), 0);
    chk("q_end_left", q_end.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
